// File: rtl/systolic_array_ctrl_if.sv
// Job-side and array-side signals of the 3x3 systolic array sequencer.
// The master modport is the sequencer. The slave modport is the operand buffers, consumer and array.
interface systolic_array_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
);
  logic                    start;
  logic                    start_ready;
  logic                    acc_keep;
  logic [9*DATA_WIDTH-1:0] a_mat;
  logic [9*DATA_WIDTH-1:0] b_mat;
  logic                    busy;
  logic                    arr_clr;
  logic                    arr_en;
  logic [3*DATA_WIDTH-1:0] arr_left;
  logic [3*DATA_WIDTH-1:0] arr_top;
  logic [9*ACC_WIDTH-1:0]  arr_acc;
  logic                    res_valid;
  logic                    res_ready;
  logic [9*ACC_WIDTH-1:0]  res_mat;

  modport master (
    input  start, acc_keep, a_mat, b_mat, arr_acc, res_ready,
    output start_ready, busy, arr_clr, arr_en, arr_left, arr_top, res_valid, res_mat
  );

  modport slave (
    output start, acc_keep, a_mat, b_mat, arr_acc, res_ready,
    input  start_ready, busy, arr_clr, arr_en, arr_left, arr_top, res_valid, res_mat
  );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Sequencer for a 3x3 systolic MAC array. It clears the array, feeds skewed A rows and B columns, then captures C.
// Latency is 10 cycles from accept to res_valid. With SA_CTRL_ACCUM_EN and acc_keep, CLEAR is skipped and latency is 9.
// Backpressure: one job at a time. start is ignored unless IDLE, and C is held until res_ready.
module systolic_array_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int N          = 3
) (
  input logic                   clk,
  input logic                   rst,
  systolic_array_ctrl_if.master bus
);
  localparam int DW = DATA_WIDTH;
  localparam logic [2:0] FEED_LAST  = 3'(2*N - 2);
  localparam logic [2:0] DRAIN_LAST = 3'(N - 2);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE} state_e;

  state_e                 state_q;
  logic [2:0]             step_q;
  logic [2:0]             step_d;
  logic [9*DW-1:0]        a_q;
  logic [9*DW-1:0]        b_q;
  logic                   busy_q;
  logic                   arr_clr_q;
  logic                   arr_en_q;
  logic                   res_valid_q;
  logic [3*DW-1:0]        arr_left_q;
  logic [3*DW-1:0]        arr_top_q;
  logic [9*ACC_WIDTH-1:0] res_mat_q;

  // Row i of the left edge carries A[i][t-i], and column j of the top edge carries B[t-j][j].
  function automatic logic [3*DW-1:0] skew_left(input logic [9*DW-1:0] m, input logic [2:0] t);
    logic [3*DW-1:0] v;
    int k;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      k = int'(t) - i;
      if (k >= 0 && k <= 2) v[i*DW +: DW] = m[(i*3 + k)*DW +: DW];
    end
    return v;
  endfunction

  function automatic logic [3*DW-1:0] skew_top(input logic [9*DW-1:0] m, input logic [2:0] t);
    logic [3*DW-1:0] v;
    int k;
    v = '0;
    for (int j = 0; j < 3; j++) begin
      k = int'(t) - j;
      if (k >= 0 && k <= 2) v[j*DW +: DW] = m[(k*3 + j)*DW +: DW];
    end
    return v;
  endfunction

  assign step_d = step_q + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      busy_q      <= 1'b0;
      arr_clr_q   <= 1'b0;
      arr_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      arr_left_q  <= '0;
      arr_top_q   <= '0;
      res_mat_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a_mat;
            b_q    <= bus.b_mat;
            busy_q <= 1'b1;
            step_q <= '0;
`ifdef SA_CTRL_ACCUM_EN
            if (bus.acc_keep) begin
              state_q    <= FEED;
              arr_en_q   <= 1'b1;
              arr_left_q <= skew_left(bus.a_mat, 3'd0);
              arr_top_q  <= skew_top(bus.b_mat, 3'd0);
            end else begin
              state_q   <= CLEAR;
              arr_clr_q <= 1'b1;
            end
`else
            state_q   <= CLEAR;
            arr_clr_q <= 1'b1;
`endif
          end
        end
        CLEAR: begin
          state_q    <= FEED;
          step_q     <= '0;
          arr_clr_q  <= 1'b0;
          arr_en_q   <= 1'b1;
          arr_left_q <= skew_left(a_q, 3'd0);
          arr_top_q  <= skew_top(b_q, 3'd0);
        end
        FEED: begin
          if (step_q == FEED_LAST) begin
            state_q    <= DRAIN;
            step_q     <= '0;
            arr_left_q <= '0;
            arr_top_q  <= '0;
          end else begin
            step_q     <= step_d;
            arr_left_q <= skew_left(a_q, step_d);
            arr_top_q  <= skew_top(b_q, step_d);
          end
        end
        DRAIN: begin
          if (step_q == DRAIN_LAST) begin
            state_q  <= CAPTURE;
            step_q   <= '0;
            arr_en_q <= 1'b0;
          end else begin
            step_q <= step_d;
          end
        end
        CAPTURE: begin
          // The last enabled edge was one cycle ago, so the accumulators are final now.
          res_mat_q   <= bus.arr_acc;
          res_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef SA_CTRL_ACCUM_EN
  logic unused_acc_keep;
  assign unused_acc_keep = bus.acc_keep;
`endif

  assign bus.start_ready = (state_q == IDLE);
  assign bus.busy        = busy_q;
  assign bus.arr_clr     = arr_clr_q;
  assign bus.arr_en      = arr_en_q;
  assign bus.arr_left    = arr_left_q;
  assign bus.arr_top     = arr_top_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_mat     = res_mat_q;
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl, with a behavioural 3x3 output-stationary array attached to its edges.
module tb_systolic_array_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_array_ctrl_if #(.DATA_WIDTH(8), .ACC_WIDTH(32)) sif ();

  systolic_array_ctrl #(.DATA_WIDTH(8), .ACC_WIDTH(32), .N(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  // Array model: PE(r,c) adds left*top products. Operands move right and down one PE per enabled cycle.
  logic [7:0]  ah [3][3];
  logic [7:0]  bv [3][3];
  logic [7:0]  a_in [3][3];
  logic [7:0]  b_in [3][3];
  logic [31:0] acc [3][3];

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      a_in[r][0] = sif.arr_left[r*8 +: 8];
      for (int c = 1; c < 3; c++) a_in[r][c] = ah[r][c-1];
    end
    for (int c = 0; c < 3; c++) begin
      b_in[0][c] = sif.arr_top[c*8 +: 8];
      for (int r = 1; r < 3; r++) b_in[r][c] = bv[r-1][c];
    end
  end

  always @(posedge clk) begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (rst || sif.arr_clr) begin
          ah[r][c]  <= '0;
          bv[r][c]  <= '0;
          acc[r][c] <= '0;
        end else if (sif.arr_en) begin
          ah[r][c]  <= a_in[r][c];
          bv[r][c]  <= b_in[r][c];
          acc[r][c] <= acc[r][c] + {24'b0, a_in[r][c]} * {24'b0, b_in[r][c]};
        end
      end
    end
  end

  always_comb begin
    sif.arr_acc = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) sif.arr_acc[(r*3+c)*32 +: 32] = acc[r][c];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [71:0] m8(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    m8 = {e8[7:0], e7[7:0], e6[7:0], e5[7:0], e4[7:0], e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
  endfunction

  function automatic logic [287:0] m32(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    m32 = {e8, e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  logic [40:0] clr_mask;
  logic [40:0] en_mask;
  logic [23:0] left_log [41];
  logic [23:0] top_log  [41];

  // Call at a negedge. Observation k is the cycle after the k-th edge, counting the accept edge as edge 1.
  task automatic run_job(input logic [71:0] a, input logic [71:0] b, input logic keep, output int lat);
    sif.a_mat    = a;
    sif.b_mat    = b;
    sif.acc_keep = keep;
    sif.start    = 1'b1;
    clr_mask     = '0;
    en_mask      = '0;
    lat          = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        sif.start = 1'b0;
        sif.a_mat = ~a;
        sif.b_mat = ~b;
      end
      clr_mask[k] = sif.arr_clr;
      en_mask[k]  = sif.arr_en;
      left_log[k] = sif.arr_left;
      top_log[k]  = sif.arr_top;
      if (sif.res_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      $display("FAIL job_timeout: res_valid not seen within 40 cycles");
    end
  endtask

  typedef struct {
    string         name;
    logic [71:0]   a;
    logic [71:0]   b;
    logic [287:0]  c;
  } vec_t;

  vec_t vecs [5];
  int   lat;
  int   seen;
  logic [71:0]  ident8;
  logic [287:0] ident32;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ident8  = m8(1, 0, 0, 0, 1, 0, 0, 0, 1);
    ident32 = m32(1, 0, 0, 0, 1, 0, 0, 0, 1);
    vecs[0] = '{"ident_x_seq", ident8, m8(1, 2, 3, 4, 5, 6, 7, 8, 9), m32(1, 2, 3, 4, 5, 6, 7, 8, 9)};
    vecs[1] = '{"two_x_three", m8(2, 2, 2, 2, 2, 2, 2, 2, 2), m8(3, 3, 3, 3, 3, 3, 3, 3, 3),
                m32(18, 18, 18, 18, 18, 18, 18, 18, 18)};
    vecs[2] = '{"max_x_max", {72{1'b1}}, {72{1'b1}},
                m32(195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075)};
    vecs[3] = '{"seq_x_seq", m8(1, 2, 3, 4, 5, 6, 7, 8, 9), m8(1, 2, 3, 4, 5, 6, 7, 8, 9),
                m32(30, 36, 42, 66, 81, 96, 102, 126, 150)};
    vecs[4] = '{"asym", m8(1, 2, 0, 0, 1, 3, 4, 0, 1), m8(2, 0, 1, 1, 1, 0, 0, 3, 2),
                m32(4, 2, 1, 1, 10, 6, 8, 3, 6)};

    rst = 1'b1;
    sif.start = 1'b0;
    sif.acc_keep = 1'b0;
    sif.a_mat = '0;
    sif.b_mat = '0;
    sif.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_start_ready", sif.start_ready, 1'b1);
    check("rst_ctrl", {sif.busy, sif.arr_en, sif.arr_clr, sif.res_valid}, 4'b0000);
    check("rst_edges", {sif.arr_left, sif.arr_top}, 48'h0);
    check("rst_res_mat", sif.res_mat, 288'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      sif.res_ready = 1'b1;
      run_job(vecs[i].a, vecs[i].b, 1'b0, lat);
      check({vecs[i].name, "_latency"}, lat, 10);
      check({vecs[i].name, "_res"}, sif.res_mat, vecs[i].c);
      check({vecs[i].name, "_clr_timing"}, clr_mask, 41'h2);
      check({vecs[i].name, "_en_timing"}, en_mask, 41'h1FC);
      if (i == 1) begin
        check("skew_left_t0", left_log[2], 24'h000002);
        check("skew_left_t2", left_log[4], 24'h020202);
        check("skew_left_t4", left_log[6], 24'h020000);
        check("skew_top_t0", top_log[2], 24'h000003);
        check("skew_top_t4", top_log[6], 24'h030000);
        check("drain_edges", {left_log[7], top_log[7]}, 48'h0);
      end
      @(posedge clk);
      @(negedge clk);
      check({vecs[i].name, "_after_hs"}, {sif.start_ready, sif.busy, sif.res_valid}, 3'b100);
    end

    // Consumer stalls for 6 cycles while new start requests arrive.
    sif.res_ready = 1'b0;
    run_job(vecs[4].a, vecs[4].b, 1'b0, lat);
    check("bp_latency", lat, 10);
    for (int w = 0; w < 6; w++) begin
      sif.start = 1'b1;
      sif.a_mat = {72{1'b1}};
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_flags", {sif.res_valid, sif.start_ready, sif.busy, sif.arr_clr}, 4'b1010);
      check("bp_hold_res", sif.res_mat, vecs[4].c);
    end
    sif.start = 1'b0;
    sif.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release", {sif.start_ready, sif.busy, sif.res_valid, sif.arr_clr}, 4'b1000);
    check("bp_res_kept", sif.res_mat, vecs[4].c);

    // Reset during FEED t=2 drops the job.
    sif.a_mat = m8(9, 9, 9, 9, 9, 9, 9, 9, 9);
    sif.b_mat = m8(9, 9, 9, 9, 9, 9, 9, 9, 9);
    sif.start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) sif.start = 1'b0;
    end
    check("mid_feed_en", {sif.arr_en, sif.arr_left}, {1'b1, 24'h090909});
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_state", {sif.start_ready, sif.arr_en, sif.arr_clr, sif.busy, sif.res_valid}, 5'b10000);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (sif.res_valid) seen++;
    end
    check("mid_rst_no_result", seen, 0);
    run_job(ident8, ident8, 1'b0, lat);
    check("post_rst_latency", lat, 10);
    check("post_rst_res", sif.res_mat, ident32);
    @(posedge clk);
    @(negedge clk);

`ifdef SA_CTRL_ACCUM_EN
    run_job(ident8, ident8, 1'b0, lat);
    check("acc_job1_latency", lat, 10);
    check("acc_job1_res", sif.res_mat, ident32);
    @(posedge clk);
    @(negedge clk);
    run_job(ident8, ident8, 1'b1, lat);
    check("acc_job2_latency", lat, 9);
    check("acc_job2_res", sif.res_mat, m32(2, 0, 0, 0, 2, 0, 0, 0, 2));
    check("acc_job2_no_clr", clr_mask, 41'h0);
    check("acc_job2_en_timing", en_mask, 41'hFE);
`else
    run_job(ident8, ident8, 1'b1, lat);
    check("keep_ignored_latency", lat, 10);
    check("keep_ignored_res", sif.res_mat, ident32);
    check("keep_ignored_clr", clr_mask, 41'h2);
`endif
    @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
